b_24_ctrl: RTL and testbench

B_24_CTRL -- requirements
Module: b_24_ctrl

---
 rtl/b_24_ctrl_if.sv | 21 ++
 rtl/b_24_ctrl.sv | 161 ++++++++++++++++
 tb/tb_b_24_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/b_24_ctrl_if.sv
// Counter-side bus of the 24-second shot-clock controller: preset/load/enable
// strobes toward the BCD counter and the count fed back from it.
interface b_24_ctrl_if;
    logic [3:0] num1;
    logic [3:0] num0;
    logic       PE;
    logic       CEP;
    logic       CET;
    logic [3:0] D1;
    logic [3:0] D0;

    modport master (
        input  num1, num0,
        output PE, CEP, CET, D1, D0
    );

    modport slave (
        output num1, num0,
        input  PE, CEP, CET, D1, D0
    );
endinterface

// File: rtl/b_24_ctrl.sv
// Shot-clock controller: synchronizes and debounces four push buttons and
// sequences an external BCD down-counter through load/pause/run/expired.
module b_24_ctrl #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic              CP,
    input  logic              CR,
    input  logic              key_start,
    input  logic              key_r24,
    input  logic              key_r14,
    input  logic              key_lt,
    b_24_ctrl_if.master       cnt,
    output logic              LT,
    output logic              LE,
    output logic              running,
    output logic              expired
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PAUSE   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_EXPIRED = 3'd4;

    // Key index: 0 start, 1 r24, 2 r14, 3 lamp test.
    logic [3:0]          keys_s;
    logic [3:0]          sync1_r;
    logic [3:0]          sync2_r;
    logic [3:0]          deb_r;
    logic [3:0]          pulse_r;
    logic [CW-1:0]       cnt_r [4];

    logic [2:0]          state_r;
    logic [2:0]          state_nx_s;
    logic                from_run_r;
    logic                from_run_nx_s;
    logic [3:0]          d1_r;
    logic [3:0]          d0_r;
    logic [3:0]          d1_nx_s;
    logic [3:0]          d0_nx_s;
    logic                pe_r;
    logic                running_r;
    logic                expired_r;

    logic                zero_s;
    logic                lt14_s;
    logic                r24_s;
    logic                r14_s;
    logic                start_s;

    // Count is below 14 only when both digits are valid BCD.
    function automatic logic below14(input logic [3:0] t, input logic [3:0] u);
        return (u <= 4'd9) && ((t == 4'd0) || ((t == 4'd1) && (u < 4'd4)));
    endfunction

    assign keys_s = {key_lt, key_r14, key_r24, key_start};

    // Two-flop synchronizers, debounce counters and single-cycle press pulses.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            sync1_r <= 4'd0;
            sync2_r <= 4'd0;
            deb_r   <= 4'd0;
            pulse_r <= 4'd0;
            for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
        end else begin
            sync1_r <= keys_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i]   <= '0;
                    pulse_r[i] <= 1'b0;
                end else if (cnt_r[i] == DEB_LAST) begin
                    cnt_r[i]   <= '0;
                    deb_r[i]   <= sync2_r[i];
                    pulse_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i]   <= cnt_r[i] + CW'(1);
                    pulse_r[i] <= 1'b0;
                end
            end
        end
    end

    assign zero_s  = (cnt.num1 == 4'd0) && (cnt.num0 == 4'd0);
    assign lt14_s  = below14(cnt.num1, cnt.num0);
    assign r24_s   = pulse_r[1];
    assign r14_s   = pulse_r[2] && lt14_s && !pulse_r[1];
    assign start_s = pulse_r[0] && !pulse_r[1] && !pulse_r[2];

    // Next-state, preset value and LOAD return target.
    always_comb begin
        state_nx_s    = state_r;
        from_run_nx_s = from_run_r;
        d1_nx_s       = d1_r;
        d0_nx_s       = d0_r;
        case (state_r)
            S_LOAD: begin
                state_nx_s = from_run_r ? S_RUN : S_PAUSE;
            end
            S_IDLE, S_PAUSE, S_RUN, S_EXPIRED: begin
                if (r24_s) begin
                    state_nx_s    = S_LOAD;
                    from_run_nx_s = (state_r == S_RUN);
                    d1_nx_s       = 4'd2;
                    d0_nx_s       = 4'd4;
                end else if (r14_s) begin
                    state_nx_s    = S_LOAD;
                    from_run_nx_s = (state_r == S_RUN);
                    d1_nx_s       = 4'd1;
                    d0_nx_s       = 4'd4;
                end else if (start_s && (state_r == S_PAUSE)) begin
                    state_nx_s = S_RUN;
                end else if (start_s && (state_r == S_RUN)) begin
                    state_nx_s = S_PAUSE;
                end else if ((state_r == S_RUN) && zero_s) begin
                    state_nx_s = S_EXPIRED;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State and registered status/strobe outputs.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_r    <= S_IDLE;
            from_run_r <= 1'b0;
            d1_r       <= 4'd2;
            d0_r       <= 4'd4;
            pe_r       <= 1'b1;
            running_r  <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            from_run_r <= from_run_nx_s;
            d1_r       <= d1_nx_s;
            d0_r       <= d0_nx_s;
            pe_r       <= (state_nx_s != S_LOAD);
            running_r  <= (state_nx_s == S_RUN);
            expired_r  <= (state_nx_s == S_EXPIRED);
        end
    end

    // Enables follow the live count so the counter never steps past 00.
    assign cnt.CEP = (state_r == S_RUN) && !zero_s;
    assign cnt.CET = (state_r == S_RUN) && !zero_s;
    assign cnt.PE  = pe_r;
    assign cnt.D1  = d1_r;
    assign cnt.D0  = d0_r;
    assign LT      = ~deb_r[3];
    assign LE      = 1'b0;
    assign running = running_r;
    assign expired = expired_r;
endmodule

// File: tb/tb_b_24_ctrl.sv
// Directed bench for b_24_ctrl with a short debounce interval.
module tb_b_24_ctrl;
    logic CP = 1'b0;
    logic CR = 1'b0;
    logic key_start = 1'b0;
    logic key_r24 = 1'b0;
    logic key_r14 = 1'b0;
    logic key_lt = 1'b0;
    logic LT, LE, running, expired;

    int total = 0;
    int bad = 0;
    int pe_cnt = 0;
    int pe_base = 0;
    logic [3:0] d1_seen = 4'd0;
    logic [3:0] d0_seen = 4'd0;

    b_24_ctrl_if bus ();

    b_24_ctrl #(.DEB_CYCLES(4)) dut (
        .CP(CP), .CR(CR),
        .key_start(key_start), .key_r24(key_r24),
        .key_r14(key_r14), .key_lt(key_lt),
        .cnt(bus.master),
        .LT(LT), .LE(LE), .running(running), .expired(expired)
    );

    always #5 CP = ~CP;

    // Count PE-low cycles and capture the preset seen during them.
    always @(negedge CP) begin
        if (CR && !bus.PE) begin
            pe_cnt  <= pe_cnt + 1;
            d1_seen <= bus.D1;
            d0_seen <= bus.D0;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_num(input int t, input int u);
        bus.num1 = 4'(t);
        bus.num0 = 4'(u);
    endtask

    // Hold the key mask {lt,r14,r24,start} for 'hold' cycles, then let it settle.
    task automatic press(input logic [3:0] m, input int hold);
        pe_base = pe_cnt;
        {key_lt, key_r14, key_r24, key_start} = m;
        repeat (hold) @(negedge CP);
        {key_lt, key_r14, key_r24, key_start} = 4'b0000;
        repeat (10) @(negedge CP);
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_pe"}, int'(bus.PE), 1);
        check_val({tag, "_cep"}, int'(bus.CEP), 0);
        check_val({tag, "_cet"}, int'(bus.CET), 0);
        check_val({tag, "_d1"}, int'(bus.D1), 2);
        check_val({tag, "_d0"}, int'(bus.D0), 4);
        check_val({tag, "_lt"}, int'(LT), 1);
        check_val({tag, "_le"}, int'(LE), 0);
        check_val({tag, "_run"}, int'(running), 0);
        check_val({tag, "_exp"}, int'(expired), 0);
    endtask

    initial begin
        set_num(2, 4);
        #12;
        check_reset_outs("rst");
        @(negedge CP);
        CR = 1'b1;
        repeat (2) @(negedge CP);

        // IDLE ignores start
        press(4'b0001, 8);
        check_val("idle_start_run", int'(running), 0);

        // r24 load -> PAUSE
        press(4'b0010, 8);
        check_val("r24_pe_cycles", pe_cnt - pe_base, 1);
        check_val("r24_d1", int'(d1_seen), 2);
        check_val("r24_d0", int'(d0_seen), 4);
        check_val("pause_run", int'(running), 0);
        check_val("pause_cep", int'(bus.CEP), 0);

        // start toggles run/pause
        press(4'b0001, 8);
        check_val("start_run", int'(running), 1);
        check_val("start_cep", int'(bus.CEP), 1);
        check_val("start_cet", int'(bus.CET), 1);
        press(4'b0001, 8);
        check_val("stop_run", int'(running), 0);
        check_val("stop_cep", int'(bus.CEP), 0);

        // count to zero -> EXPIRED
        press(4'b0001, 8);
        set_num(0, 1);
        #1;
        check_val("n01_cep", int'(bus.CEP), 1);
        @(negedge CP);
        set_num(0, 0);
        #1;
        check_val("n00_cep", int'(bus.CEP), 0);
        check_val("n00_exp_early", int'(expired), 0);
        @(negedge CP);
        check_val("expired", int'(expired), 1);
        check_val("exp_run", int'(running), 0);
        press(4'b0001, 8);
        check_val("exp_start_ign", int'(expired), 1);

        // EXPIRED r24 -> LOAD -> PAUSE
        press(4'b0010, 8);
        check_val("exp_load_pe", pe_cnt - pe_base, 1);
        check_val("exp_load_exp", int'(expired), 0);
        check_val("exp_load_run", int'(running), 0);

        // r14 gating while running
        set_num(1, 8);
        press(4'b0001, 8);
        check_val("run2", int'(running), 1);
        press(4'b0100, 8);
        check_val("r14_18_pe", pe_cnt - pe_base, 0);
        set_num(0, 9);
        press(4'b0100, 8);
        check_val("r14_09_pe", pe_cnt - pe_base, 1);
        check_val("r14_d1", int'(d1_seen), 1);
        check_val("r14_d0", int'(d0_seen), 4);
        check_val("r14_back_run", int'(running), 1);

        // simultaneous r24+r14 -> single 24 load
        press(4'b0110, 8);
        check_val("both_pe", pe_cnt - pe_base, 1);
        check_val("both_d1", int'(d1_seen), 2);
        check_val("both_d0", int'(d0_seen), 4);

        // 2-cycle glitch on start
        press(4'b0001, 2);
        check_val("glitch_run", int'(running), 1);

        // lamp test
        key_lt = 1'b1;
        repeat (3) @(negedge CP);
        check_val("lt_early", int'(LT), 1);
        repeat (6) @(negedge CP);
        check_val("lt_on", int'(LT), 0);
        check_val("lt_run", int'(running), 1);

        // async reset mid-RUN, r24 held through it
        key_r24 = 1'b1;
        @(negedge CP);
        CR = 1'b0;
        #1;
        check_reset_outs("mid");
        key_lt = 1'b0;
        repeat (3) @(negedge CP);
        pe_base = pe_cnt;
        CR = 1'b1;
        repeat (4) @(negedge CP);
        check_val("held_early_pe", pe_cnt - pe_base, 0);
        repeat (8) @(negedge CP);
        check_val("held_late_pe", pe_cnt - pe_base, 1);
        key_r24 = 1'b0;
        repeat (4) @(negedge CP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
